// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, default payload width and a
// compile-time clog2 helper used for the derived pointer and counter widths.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } tx_state_e;

    // Minimum bit width needed to hold the values 0..v-1 (at least 1 bit).
    function automatic int clog2(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr,
// wrapping modulo N. Returns a one-hot grant, its index and a valid flag.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    // Scan N slots starting at ptr; first hit wins.
    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares a single UART transmitter between NUM_REQ byte producers. Each frame
// is granted round-robin, started with a one-cycle startTx, tracked through
// the transmitter's busy flag and closed with a one-cycle ack. A watchdog
// closes the frame with txErr if busy never rises after startTx.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = DATA_BITS_DEF,
    parameter int START_TIMEOUT = 16,
    localparam int PTR_W        = clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] reqData,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         txErr,
    output logic [DATA_BITS-1:0]         dataTx,
    output logic                         startTx,
    input  logic                         uartBusyTx
);

    localparam int CNT_W = clog2(START_TIMEOUT + 1);

    tx_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   tx_err_q, tx_err_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   start_q, start_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        tx_err_d = 1'b0;
        start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Only launch when the transmitter is quiet, which also keeps
                // us off a frame that was in flight across a reset.
                if (arb_valid && !uartBusyTx) begin
                    grant_d = arb_gnt;
                    idx_d   = arb_idx;
                    data_d  = reqData[int'(arb_idx)*DATA_BITS +: DATA_BITS];
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uartBusyTx) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(START_TIMEOUT)) begin
                        state_d  = ACK;
                        ack_d    = grant_q;
                        tx_err_d = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                // Frame length belongs to the transmitter; no watchdog here.
                if (!uartBusyTx) begin
                    state_d = ACK;
                    ack_d   = grant_q;
                end
            end
            ACK: begin
                grant_d = '0;
                ptr_d   = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            tx_err_q <= 1'b0;
            data_q   <= '0;
            start_q  <= 1'b0;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            tx_err_q <= tx_err_d;
            data_q   <= data_d;
            start_q  <= start_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack     = ack_q;
    assign grant   = grant_q;
    assign txErr   = tx_err_q;
    assign dataTx  = data_q;
    assign startTx = start_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uartTxMod transmitter between NUM_REQ requesters using round-robin arbitration.
- Sequences each frame: latches the granted byte, pulses startTx, tracks uartBusyTx rise and fall, then acks the requester.
- Sits between on-chip byte producers (debug console, DMA, CPU port) and the single UART TX pin.
- Includes a start-timeout watchdog so a stuck transmitter cannot hang the requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, frame payload width; must match uartTxMod.
- START_TIMEOUT, 16, clk cycles allowed between startTx and uartBusyTx rising.
- PTR_W, $clog2(NUM_REQ), round-robin pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until the matching ack.
- reqData  in  NUM_REQ*DATA_BITS  packed bytes; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- txErr  out  1  one-cycle pulse, coincident with ack, when the start timeout expired.
- dataTx  out  DATA_BITS  byte to uartTxMod.
- startTx  out  1  one-cycle start pulse to uartTxMod.
- uartBusyTx  in  1  busy flag from uartTxMod.

Behaviour:
- Reset values: ack=0, grant=0, txErr=0, dataTx=0, startTx=0, state=IDLE, pointer=0, timeout counter=0. rst overrides everything, including mid-frame; uartTxMod is not aborted by this block. After reset the block stays in IDLE until uartBusyTx reads 0.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE → START:
  - Taken when any req is high and uartBusyTx=0.
  - Winner is the first set req scanning from pointer upward, wrapping modulo NUM_REQ.
  - Registers grant (one-hot) and dataTx = the winner's reqData slice.
- START:
  - startTx=1 for exactly this one cycle. Counter cleared.
  - Next state WAIT_BUSY.
- WAIT_BUSY:
  - uartBusyTx=1 → WAIT_DONE.
  - Otherwise the counter increments; reaching START_TIMEOUT → ACK with the error flag set.
- WAIT_DONE:
  - uartBusyTx falling to 0 → ACK.
  - No timeout in this state; frame length is owned by uartTxMod.
- ACK:
  - ack[winner]=1 for one cycle; txErr=1 in the same cycle if the timeout fired.
  - grant clears. pointer = winner+1, wrapping from NUM_REQ-1 to 0.
  - Next state IDLE.
- Latency:
  - req in IDLE at edge t → grant/dataTx valid after edge t+1; startTx high during cycle t+1.
  - Earliest next grant is the cycle after ACK.
- dataTx and grant hold stable from START until ACK. reqData changes after the grant are ignored.
- req dropped mid-transfer: the transfer still completes and ack is still issued. Requesters must not withdraw.
- req still high in the ACK cycle: treated as a fresh request in IDLE. Round-robin gives other pending requesters priority.
- Simultaneous requests: exactly one grant; the others wait with no loss.
- Single requester: back-to-back frames, with one idle cycle between ACK and the next START.
- ack, grant and startTx are never asserted for more than one requester or more than one cycle, except grant, which is held for the whole transfer.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE, ACK).
  - Default DATA_BITS=8 and the clog2 helper, reused by uartTxMod/uartRxMod configs.
- One natural sub-module, rr_arbiter: combinational round-robin priority pick (req, pointer → one-hot winner plus index).
  - Reusable for a later RX-buffer scheduler.
- The FSM and timeout counter stay in uart_tx_arbiter.

Test Plan:
1. Reset: hold rst 3 cycles, then drive req=4'b1111 during rst → grant=0, startTx=0, ack=0 throughout. First grant is 4'b0001 once uartBusyTx=0.
2. Single request: req[2]=1, reqData[2]=8'hA5, real uartTxMod with CLOCK_DIV=54 → one startTx pulse, dataTx=8'hA5, ack[2] only after uartBusyTx falls. Looped-back uartRxMod gives dataRx=8'hA5 and uartErrRx=0.
3. Contention: req=4'b1111 with bytes 11/22/33/44 held continuously → frames transmitted in order 11,22,33,44,11. Each ack is a one-cycle pulse in matching order.
4. Wrap/fairness: pointer=3, req=4'b1001 → requester 3 served first, then 0. Pointer ends at 1.
5. Timeout: stub uartBusyTx tied 0, req[1]=1 → ack[1] and txErr pulse together exactly START_TIMEOUT+1 cycles after startTx. FSM returns to IDLE.
6. Reset mid-frame: assert rst while in WAIT_DONE → all outputs 0 next cycle. No ack issued. A new grant occurs only after uartBusyTx deasserts.
